i2s_clk_gen: RTL and testbench

Parametrised I2S/TDM serial-clock generator with glitch-free runtime reconfiguration, odd divide support and frame sequencing. It divides the system clock into a bit clock (bclk) and derives a frame-sync/LR clock plus bit and slot indices. It replaces the bare even-only divider at the head of the i2s transmit/receive path. Serialisers consume its edge strobes and indices instead of re-deriving bclk.

---
 rtl/i2s_pkg.sv | 24 ++
 rtl/i2s_bclk_div.sv | 55 +++++
 rtl/i2s_clk_gen.sv | 161 ++++++++++++++++
 tb/tb_i2s_clk_gen.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared constants for the I2S/TDM clock generator: fsync modes, FSM encoding
// and the minimum legal values the shadow configuration is clamped to.
package i2s_pkg;

    localparam logic MODE_LR  = 1'b0;
    localparam logic MODE_TDM = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    localparam int unsigned DIV_MIN   = 2;
    localparam int unsigned BITS_MIN  = 2;
    localparam int unsigned SLOTS_MIN = 1;

    function automatic int unsigned clamp_u(input int unsigned v,
                                            input int unsigned lo,
                                            input int unsigned hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/i2s_bclk_div.sv
// Bit-clock divider: bclk is low for ceil(div/2) clk cycles then high for floor(div/2).
// period_end marks the last clk of a bclk period so the caller can step its counters in lockstep.
module i2s_bclk_div #(
    parameter int DIV_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             bclk,
    output logic             bclk_rise,
    output logic             bclk_fall,
    output logic             period_end
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W:0]   high_from;
    logic             bclk_q;
    logic             bclk_d;
    logic             rise_q;
    logic             fall_q;

    assign high_from  = ({1'b0, div} + (DIV_W+1)'(1)) >> 1;
    assign period_end = run && (cnt_q == div - DIV_W'(1));

    always_comb begin
        cnt_d = '0;
        if (run && !period_end) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // div is never below 2 while running, so a zero count always lands in the low phase.
    assign bclk_d = run && ({1'b0, cnt_d} >= high_from);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            bclk_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            bclk_q <= bclk_d;
            rise_q <= bclk_d & ~bclk_q;
            fall_q <= ~bclk_d & bclk_q;
        end
    end

    assign bclk      = bclk_q;
    assign bclk_rise = rise_q;
    assign bclk_fall = fall_q;

endmodule

// File: rtl/i2s_clk_gen.sv
// I2S/TDM serial-clock generator: bclk, fsync and bit/slot indices derived from clk.
// Configuration is captured only at frame boundaries, so runtime changes never produce runt pulses.
module i2s_clk_gen
    import i2s_pkg::*;
#(
    parameter int MAX_DIV       = 64,
    parameter int MAX_SLOT_BITS = 32,
    parameter int MAX_SLOTS     = 8,
    localparam int DIV_W  = $clog2(MAX_DIV + 1),
    localparam int BIT_W  = $clog2(MAX_SLOT_BITS + 1),
    localparam int SLOT_W = $clog2(MAX_SLOTS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              mode,
    input  logic [DIV_W-1:0]  bclk_div,
    input  logic [BIT_W-1:0]  slot_bits,
    input  logic [SLOT_W-1:0] slots,
    output logic              bclk,
    output logic              fsync,
    output logic              bclk_rise,
    output logic              bclk_fall,
    output logic              frame_start,
    output logic [BIT_W-1:0]  bit_idx,
    output logic [SLOT_W-1:0] slot_idx,
    output logic              busy
);

    logic [1:0]        state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bits_q, bits_d;
    logic [SLOT_W-1:0] slots_q, slots_d;
    logic              mode_q, mode_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              fsync_q, fsync_d;
    logic              fstart_q, fstart_d;
    logic              busy_q, busy_d;
    logic [SLOT_W:0]   half_slots;

    logic run;
    logic period_end;
    logic last_bit;
    logic last_slot;
    logic frame_end;
    logic start;
    logic latch_cfg;

    assign run       = (state_q != ST_IDLE);
    assign last_bit  = (bit_q == bits_q - BIT_W'(1));
    assign last_slot = (slot_q == slots_q - SLOT_W'(1));
    assign frame_end = period_end && last_bit && last_slot;
    assign start     = (state_q == ST_IDLE) && enable;
    assign latch_cfg = start || (frame_end && enable);

    i2s_bclk_div #(
        .DIV_W (DIV_W)
    ) u_bclk_div (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .div        (div_q),
        .bclk       (bclk),
        .bclk_rise  (bclk_rise),
        .bclk_fall  (bclk_fall),
        .period_end (period_end)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable) state_d = ST_RUN;
            ST_RUN: begin
                if (frame_end)   state_d = enable ? ST_RUN : ST_IDLE;
                else if (!enable) state_d = ST_STOP;
            end
            ST_STOP: if (frame_end) state_d = enable ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        div_d   = div_q;
        bits_d  = bits_q;
        slots_d = slots_q;
        mode_d  = mode_q;
        if (latch_cfg) begin
            div_d   = DIV_W'(clamp_u(32'(bclk_div), DIV_MIN, MAX_DIV));
            bits_d  = BIT_W'(clamp_u(32'(slot_bits), BITS_MIN, MAX_SLOT_BITS));
            slots_d = SLOT_W'(clamp_u(32'(slots), SLOTS_MIN, MAX_SLOTS));
            mode_d  = mode;
        end
    end

    // Indices step together with the falling bclk edge the divider is about to emit.
    always_comb begin
        bit_d  = bit_q;
        slot_d = slot_q;
        if (start) begin
            bit_d  = '0;
            slot_d = '0;
        end else if (period_end) begin
            if (last_bit) begin
                bit_d  = '0;
                slot_d = last_slot ? '0 : slot_q + SLOT_W'(1);
            end else begin
                bit_d = bit_q + BIT_W'(1);
            end
        end
    end

    always_comb begin
        half_slots = ({1'b0, slots_d} + (SLOT_W+1)'(1)) >> 1;
        fsync_d    = 1'b0;
        if (state_d != ST_IDLE) begin
            if (mode_d == MODE_TDM) begin
                fsync_d = (slot_d == '0) && (bit_d == '0);
            end else begin
                fsync_d = ({1'b0, slot_d} >= half_slots);
            end
        end
    end

    // busy spans the closing bclk_fall cycle of a stopping frame and drops one clk later.
    assign busy_d   = (state_d != ST_IDLE) || (state_q != ST_IDLE);
    assign fstart_d = latch_cfg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            div_q    <= '0;
            bits_q   <= '0;
            slots_q  <= '0;
            mode_q   <= 1'b0;
            bit_q    <= '0;
            slot_q   <= '0;
            fsync_q  <= 1'b0;
            fstart_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bits_q   <= bits_d;
            slots_q  <= slots_d;
            mode_q   <= mode_d;
            bit_q    <= bit_d;
            slot_q   <= slot_d;
            fsync_q  <= fsync_d;
            fstart_q <= fstart_d;
            busy_q   <= busy_d;
        end
    end

    assign fsync       = fsync_q;
    assign frame_start = fstart_q;
    assign bit_idx     = bit_q;
    assign slot_idx    = slot_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_i2s_clk_gen.sv
// Bench for i2s_clk_gen: a frame-level model queues expected frames as stimulus is issued,
// and a monitor checks every output cycle of each frame against arithmetic on its config.
module tb_i2s_clk_gen;

    localparam int MAX_DIV       = 64;
    localparam int MAX_SLOT_BITS = 32;
    localparam int MAX_SLOTS     = 8;
    localparam int DIV_W  = $clog2(MAX_DIV + 1);
    localparam int BIT_W  = $clog2(MAX_SLOT_BITS + 1);
    localparam int SLOT_W = $clog2(MAX_SLOTS + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              enable = 1'b0;
    logic              mode = 1'b0;
    logic [DIV_W-1:0]  bclk_div = '0;
    logic [BIT_W-1:0]  slot_bits = '0;
    logic [SLOT_W-1:0] slots = '0;
    logic              bclk, fsync, bclk_rise, bclk_fall, frame_start, busy;
    logic [BIT_W-1:0]  bit_idx;
    logic [SLOT_W-1:0] slot_idx;
    logic [15:0]       act_vec;

    i2s_clk_gen #(
        .MAX_DIV       (MAX_DIV),
        .MAX_SLOT_BITS (MAX_SLOT_BITS),
        .MAX_SLOTS     (MAX_SLOTS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .mode        (mode),
        .bclk_div    (bclk_div),
        .slot_bits   (slot_bits),
        .slots       (slots),
        .bclk        (bclk),
        .fsync       (fsync),
        .bclk_rise   (bclk_rise),
        .bclk_fall   (bclk_fall),
        .frame_start (frame_start),
        .bit_idx     (bit_idx),
        .slot_idx    (slot_idx),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    assign act_vec = {busy, frame_start, fsync, bclk, bclk_rise, bclk_fall, slot_idx, bit_idx};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_end;
        int at;
        int div;
        int bits;
        int slots;
        bit md;
        bit chained;
    } desc_t;

    desc_t sb[$];
    int    total = 0;
    int    bad = 0;
    bit    mon_en = 1'b0;
    bit    m_run = 1'b0;
    int    m_left = 0;

    task automatic chk(input string nm, input longint a, input longint e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, a, e);
        end
    endtask

    function automatic int lim(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic desc_t take_cfg(input bit ch);
        desc_t d;
        d.is_end  = 1'b0;
        d.at      = cyc + 1;
        d.div     = lim(int'(bclk_div), 2, MAX_DIV);
        d.bits    = lim(int'(slot_bits), 2, MAX_SLOT_BITS);
        d.slots   = lim(int'(slots), 1, MAX_SLOTS);
        d.md      = mode;
        d.chained = ch;
        return d;
    endfunction

    // One clock of stimulus: decide what the coming edge does at frame level, then advance.
    task automatic tick();
        desc_t d;
        if (!m_run) begin
            if (enable) begin
                d = take_cfg(1'b0);
                sb.push_back(d);
                m_run  = 1'b1;
                m_left = d.div * d.bits * d.slots;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                if (enable) begin
                    d = take_cfg(1'b1);
                    sb.push_back(d);
                    m_left = d.div * d.bits * d.slots;
                end else begin
                    d.is_end = 1'b1;
                    d.at     = cyc + 1;
                    sb.push_back(d);
                    m_run = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic cfg(input logic md, input int d, input int b, input int s);
        mode      = md;
        bclk_div  = DIV_W'(d);
        slot_bits = BIT_W'(b);
        slots     = SLOT_W'(s);
    endtask

    function automatic logic [15:0] exp_vec(input desc_t d, input int t);
        int  c, ph, p, bi, sl;
        logic fs;
        c  = (d.div + 1) / 2;
        ph = t % d.div;
        p  = t / d.div;
        bi = p % d.bits;
        sl = p / d.bits;
        fs = d.md ? (p == 0) : (sl >= (d.slots + 1) / 2);
        return {1'b1, t == 0, fs, ph >= c, ph == c, (ph == 0) && (t > 0 || d.chained),
                4'(sl), 6'(bi)};
    endfunction

    bit    in_frame = 1'b0;
    int    t = 0;
    desc_t cur;
    desc_t nxt;

    initial begin
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                in_frame = 1'b0;
            end else if (!in_frame) begin
                if (frame_start) begin
                    chk("sb_pending", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        cur = sb.pop_front();
                        chk("start_cycle", cyc, cur.at);
                        t = 0;
                        in_frame = 1'b1;
                        chk("cycle", act_vec, exp_vec(cur, 0));
                    end
                end else begin
                    chk("idle", act_vec, 0);
                end
            end else begin
                t++;
                if (t == cur.div * cur.bits * cur.slots) begin
                    chk("sb_pending", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        nxt = sb.pop_front();
                        if (!nxt.is_end) begin
                            chk("chained_start", frame_start, 1);
                            chk("start_cycle", cyc, nxt.at);
                            cur = nxt;
                            t = 0;
                            chk("cycle", act_vec, exp_vec(cur, 0));
                        end else begin
                            chk("end_cycle", cyc, nxt.at);
                            chk("stop_end", act_vec, 16'h8400);
                            in_frame = 1'b0;
                        end
                    end else begin
                        in_frame = 1'b0;
                    end
                end else begin
                    chk("cycle", act_vec, exp_vec(cur, t));
                end
            end
        end
    end

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", act_vec, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        cfg(0, 4, 16, 2);  enable = 1'b1; run(300);
        cfg(0, 5, 16, 2);  run(400);
        cfg(0, 1, 16, 2);  run(200);
        cfg(1, 2, 32, 8);  run(1100);
        cfg(0, 4, 4, 2);   run(10);
        cfg(0, 6, 4, 2);   run(100);
        enable = 1'b0;     run(600);

        enable = 1'b1;
        cfg(0, 100, 2, 1); run(300);
        cfg(1, 2, 40, 1);  run(200);
        cfg(0, 2, 2, 12);  run(100);
        cfg(0, 0, 0, 0);   run(20);
        enable = 1'b0;     run(30);

        repeat (40) begin
            cfg(1'($urandom_range(0, 1)), $urandom_range(0, 9), $urandom_range(0, 12),
                $urandom_range(0, 4));
            enable = ($urandom_range(0, 3) != 0);
            run($urandom_range(1, 200));
        end
        enable = 1'b0;
        run(500);
        @(negedge clk);
        #1;
        chk("sb_drain", sb.size(), 0);

        // Asynchronous reset while bclk is high in the middle of a frame.
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        cfg(0, 4, 16, 2);
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_bclk", bclk, 1);
        chk("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst", act_vec, 0);
        enable = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_rst", act_vec, 0);
        enable = 1'b1;
        @(posedge clk);
        #1;
        chk("restart", act_vec, 16'hC000);
        enable = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
